// File: rtl/uart_tx_engine.sv
// uart_tx_engine: 8-bit UART transmitter with optional parity and 1/2 stop bits,
// start/busy handshake, registered txd and tx_busy.
module uart_tx_engine #(
    parameter int CLK_FREQ  = 50000000,
    parameter int BAUD      = 115200,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    output logic       txd,
    output logic       tx_busy
);
    localparam int DIV = (CLK_FREQ + BAUD / 2) / BAUD;
    localparam int CW  = $clog2(DIV);

    if (DIV < 2 || PARITY < 0 || PARITY > 2 || STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_cfg
        $error("uart_tx_engine: illegal configuration (DIV=%0d)", DIV);
    end

    typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

    state_t        state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bit_cnt, bit_n;
    logic [7:0]    shift, shift_n;
    logic          par, par_n;
    logic          stop_cnt, stop_n;
    logic          txd_n;
    logic          tick;

    assign tick = cnt == CW'(DIV - 1);

    always_comb begin
        state_n = state;
        cnt_n   = tick ? '0 : cnt + 1'b1;
        bit_n   = bit_cnt;
        shift_n = shift;
        par_n   = par;
        stop_n  = stop_cnt;
        case (state)
            IDLE: begin
                cnt_n = '0;
                if (tx_start) begin
                    state_n = START;
                    shift_n = tx_data;
                    par_n   = (PARITY == 1) ? ~^tx_data : ^tx_data;
                    bit_n   = 3'd0;
                    stop_n  = 1'b0;
                end
            end
            START: if (tick) state_n = DATA;
            DATA: if (tick) begin
                shift_n = shift >> 1;
                bit_n   = bit_cnt + 3'd1;
                if (bit_cnt == 3'd7) state_n = (PARITY != 0) ? PAR : STOP;
            end
            PAR: if (tick) state_n = STOP;
            STOP: if (tick) begin
                stop_n = 1'b1;
                if (stop_cnt == 1'(STOP_BITS - 1)) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
        // Outputs are registered from the next state so txd changes on the same edge as the FSM.
        txd_n = (state_n == START) ? 1'b0 :
                (state_n == DATA)  ? shift_n[0] :
                (state_n == PAR)   ? par_n : 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            cnt      <= '0;
            bit_cnt  <= 3'd0;
            shift    <= 8'd0;
            par      <= 1'b0;
            stop_cnt <= 1'b0;
            txd      <= 1'b1;
            tx_busy  <= 1'b0;
        end else begin
            state    <= state_n;
            cnt      <= cnt_n;
            bit_cnt  <= bit_n;
            shift    <= shift_n;
            par      <= par_n;
            stop_cnt <= stop_n;
            txd      <= txd_n;
            tx_busy  <= state_n != IDLE;
        end
    end
endmodule

// File: tb/tb_uart_tx_engine.sv
// tb_uart_tx_engine: directed self-checking bench, DIV=16 for all instances
// (dut1 no parity/1 stop, dut2 even/2 stop, dut3 odd/1 stop).
module tb_uart_tx_engine;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       s1 = 1'b0, s2 = 1'b0, s3 = 1'b0;
    logic [7:0] d1 = 8'h00, d2 = 8'h00, d3 = 8'h00;
    logic       x1, x2, x3, b1, b2, b3;
    int         compared = 0;
    int         mismatched = 0;

    always #5 clk = ~clk;

    uart_tx_engine #(.CLK_FREQ(1600), .BAUD(100), .PARITY(0), .STOP_BITS(1)) dut1 (
        .clk(clk), .reset(reset), .tx_start(s1), .tx_data(d1), .txd(x1), .tx_busy(b1));
    uart_tx_engine #(.CLK_FREQ(1600), .BAUD(100), .PARITY(2), .STOP_BITS(2)) dut2 (
        .clk(clk), .reset(reset), .tx_start(s2), .tx_data(d2), .txd(x2), .tx_busy(b2));
    uart_tx_engine #(.CLK_FREQ(1600), .BAUD(100), .PARITY(1), .STOP_BITS(1)) dut3 (
        .clk(clk), .reset(reset), .tx_start(s3), .tx_data(d3), .txd(x3), .tx_busy(b3));

    task automatic wait_idle1(input string tag);
        int n = 0;
        while (b1 !== 1'b0 && n < 400) begin
            @(negedge clk);
            n++;
        end
        compared++;
        if (b1 !== 1'b0) begin
            mismatched++;
            $display("FAIL %s_timeout: tx_busy=%b expected 0", tag, b1);
        end
    endtask

    // Drives one dut1 frame; cycle k=0 is the first negedge after the accepting edge.
    task automatic frame1(input logic [7:0] d, input int inj, output int busy_n, output int errs);
        logic exp_txd;
        d1 = d;
        s1 = 1'b1;
        @(negedge clk);
        s1 = 1'b0;
        d1 = ~d;
        busy_n = 0;
        errs = 0;
        for (int k = 0; k < 176; k++) begin
            exp_txd = (k < 16) ? 1'b0 : (k < 144) ? d[(k - 16) / 16] : 1'b1;
            if (x1 !== exp_txd || b1 !== (k < 160)) errs++;
            if (b1 === 1'b1) busy_n++;
            if (k == inj) begin
                d1 = 8'h55;
                s1 = 1'b1;
            end else if (k == inj + 1) s1 = 1'b0;
            @(negedge clk);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        @(negedge clk);
        compared += 4;
        if (x1 !== 1'b1 || x2 !== 1'b1) begin mismatched++; $display("FAIL reset_txd: txd=%b/%b expected 1", x1, x2); end
        if (b1 !== 1'b0 || b2 !== 1'b0) begin mismatched++; $display("FAIL reset_busy: tx_busy=%b/%b expected 0", b1, b2); end
        if (x3 !== 1'b1) begin mismatched++; $display("FAIL reset_txd3: txd=%b expected 1", x3); end
        if (b3 !== 1'b0) begin mismatched++; $display("FAIL reset_busy3: tx_busy=%b expected 0", b3); end
        reset = 1'b0;
        @(negedge clk);
        d1 = 8'h00;
        s1 = 1'b1;
        @(negedge clk);
        s1 = 1'b0;
        repeat (4) @(negedge clk);
        compared += 2;
        if (x1 !== 1'b0) begin mismatched++; $display("FAIL pre_reset_txd: txd=%b expected 0", x1); end
        if (b1 !== 1'b1) begin mismatched++; $display("FAIL pre_reset_busy: tx_busy=%b expected 1", b1); end
        #2 reset = 1'b1;
        #1;
        compared += 2;
        if (x1 !== 1'b1) begin mismatched++; $display("FAIL async_reset_txd: txd=%b expected 1", x1); end
        if (b1 !== 1'b0) begin mismatched++; $display("FAIL async_reset_busy: tx_busy=%b expected 0", b1); end
        @(negedge clk);
        reset = 1'b0;
        repeat (20) @(negedge clk);
        compared += 2;
        if (x1 !== 1'b1) begin mismatched++; $display("FAIL post_reset_txd: txd=%b expected 1", x1); end
        if (b1 !== 1'b0) begin mismatched++; $display("FAIL post_reset_busy: tx_busy=%b expected 0", b1); end
    endtask

    task automatic test_single_byte;
        int bn, er;
        wait_idle1("single");
        frame1(8'h40, -1, bn, er);
        compared += 2;
        if (bn !== 160) begin mismatched++; $display("FAIL single_busy_len: got %0d expected 160", bn); end
        if (er !== 0) begin mismatched++; $display("FAIL single_line: %0d bad cycles expected 0", er); end
    endtask

    task automatic test_ignore_busy;
        int bn, er;
        wait_idle1("ignore");
        frame1(8'hAA, 50, bn, er);
        compared += 2;
        if (bn !== 160) begin mismatched++; $display("FAIL ignore_busy_len: got %0d expected 160", bn); end
        if (er !== 0) begin mismatched++; $display("FAIL ignore_line: %0d bad cycles expected 0", er); end
    endtask

    task automatic test_handshake;
        logic [7:0] chars [4] = '{8'h40, 8'h30, 8'h2F, 8'h0A};
        string      exp_str = "@0/\n";
        logic [7:0] got;
        logic       st;
        for (int i = 0; i < 4; i++) begin
            wait_idle1("handshake");
            d1 = chars[i];
            s1 = 1'b1;
            @(negedge clk);
            s1 = 1'b0;
            compared++;
            if (b1 !== 1'b1) begin mismatched++; $display("FAIL hs_busy_%0d: tx_busy=%b expected 1", i, b1); end
            repeat (8) @(negedge clk);
            for (int j = 0; j < 8; j++) begin
                repeat (16) @(negedge clk);
                got[j] = x1;
            end
            repeat (16) @(negedge clk);
            st = x1;
            compared++;
            if (got !== exp_str[i] || st !== 1'b1) begin
                mismatched++;
                $display("FAIL hs_char_%0d: got %h stop=%b expected %h stop=1", i, got, st, exp_str[i]);
            end
        end
    endtask

    task automatic par_frame(input int which, input logic [7:0] d, input logic exp_par, input int nstop);
        int   total = 160 + 16 * nstop;
        int   busy_n = 0, errs = 0;
        logic pbit = 1'bx;
        logic ot, ob, exp_txd;
        if (which == 2) begin d2 = d; s2 = 1'b1; end else begin d3 = d; s3 = 1'b1; end
        @(negedge clk);
        s2 = 1'b0;
        s3 = 1'b0;
        for (int k = 0; k < total + 16; k++) begin
            ot = (which == 2) ? x2 : x3;
            ob = (which == 2) ? b2 : b3;
            exp_txd = (k < 16) ? 1'b0 : (k < 144) ? d[(k - 16) / 16] : (k < 160) ? exp_par : 1'b1;
            if (ot !== exp_txd || ob !== (k < total)) errs++;
            if (ob === 1'b1) busy_n++;
            if (k == 152) pbit = ot;
            @(negedge clk);
        end
        compared += 3;
        if (pbit !== exp_par) begin mismatched++; $display("FAIL par%0d_bit: got %b expected %b", which, pbit, exp_par); end
        if (busy_n !== total) begin mismatched++; $display("FAIL par%0d_busy_len: got %0d expected %0d", which, busy_n, total); end
        if (errs !== 0) begin mismatched++; $display("FAIL par%0d_line: %0d bad cycles expected 0", which, errs); end
    endtask

    task automatic test_parity;
        par_frame(2, 8'h07, 1'b1, 2);
        par_frame(3, 8'h07, 1'b0, 1);
    endtask

    task automatic test_back_to_back;
        int n;
        wait_idle1("b2b");
        d1 = 8'hFF;
        s1 = 1'b1;
        for (int r = 0; r < 2; r++) begin
            n = 0;
            do begin
                @(negedge clk);
                n++;
            end while (b1 !== 1'b0 && n < 400);
            compared += 4;
            if (b1 !== 1'b0) begin mismatched++; $display("FAIL b2b_fall_%0d: tx_busy=%b expected 0", r, b1); end
            if (x1 !== 1'b1) begin mismatched++; $display("FAIL b2b_gap_%0d: txd=%b expected 1", r, x1); end
            @(negedge clk);
            if (x1 !== 1'b0) begin mismatched++; $display("FAIL b2b_start_%0d: txd=%b expected 0", r, x1); end
            if (b1 !== 1'b1) begin mismatched++; $display("FAIL b2b_busy_%0d: tx_busy=%b expected 1", r, b1); end
        end
        s1 = 1'b0;
        wait_idle1("b2b_end");
    endtask

    initial begin
        test_reset;
        test_single_byte;
        test_handshake;
        test_ignore_busy;
        test_parity;
        test_back_to_back;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
